// File: rtl/simon_seq_engine_if.sv
// Game-control and display bus of the Simon sequence engine.
// The master drives start/seed/guesses; the slave (the engine) returns display and status.
interface simon_seq_engine_if #(
    parameter int COLOR_W = 2,
    parameter int MAX_LEN = 16
);
    localparam int LEVEL_W = $clog2(MAX_LEN + 1);

    logic                start;
    logic [15:0]         seed;
    logic                guess_valid;
    logic [COLOR_W-1:0]  guess;
    logic                show_en;
    logic [COLOR_W-1:0]  show_color;
    logic                busy;
    logic                win;
    logic                lose;
    logic [LEVEL_W-1:0]  level;

    modport master (
        output start, seed, guess_valid, guess,
        input  show_en, show_color, busy, win, lose, level
    );

    modport slave (
        input  start, seed, guess_valid, guess,
        output show_en, show_color, busy, win, lose, level
    );
endinterface

// File: rtl/simon_seq_engine.sv
// Simon memory-game engine: LFSR-generated colour sequence, timed replay, guess checking.
// Optional input timeout is compiled in with macro SIMON_INPUT_TIMEOUT_EN.
module simon_seq_engine #(
    parameter int COLOR_W        = 2,
    parameter int MAX_LEN        = 16,
    parameter int SHOW_CYCLES    = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              resetn,
    simon_seq_engine_if.slave bus
);
    localparam int LEVEL_W = $clog2(MAX_LEN + 1);
    localparam int IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int CNT_W   = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

    localparam logic [LEVEL_W-1:0] LEVEL_ONE = LEVEL_W'(1);
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(MAX_LEN);
    localparam logic [IDX_W-1:0]   IDX_ONE   = IDX_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(SHOW_CYCLES - 1);
    localparam logic [15:0]        LFSR_INIT = 16'hACE1;

    if (COLOR_W < 1 || MAX_LEN < 1 || SHOW_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("simon_seq_engine: all parameters must be positive");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_GEN,
        S_SHOW,
        S_GAP,
        S_INPUT,
        S_WIN,
        S_LOSE
    } state_t;

    state_t              r_state;
    logic [LEVEL_W-1:0]  r_level;
    logic [IDX_W-1:0]    r_idx;
    logic [CNT_W-1:0]    r_cnt;
    logic [15:0]         r_lfsr;
    logic                r_show_en;
    logic [COLOR_W-1:0]  r_show_color;
    logic [COLOR_W-1:0]  r_mem [MAX_LEN];

    state_t              w_state_nxt;
    logic [LEVEL_W-1:0]  w_level_nxt;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [15:0]         w_lfsr_nxt;
    logic                w_mem_we;
    logic [15:0]         w_lfsr_step;
    logic [IDX_W-1:0]    w_last_idx;
    logic                w_idx_last;
    logic                w_cnt_done;
    logic [COLOR_W-1:0]  w_entry;
    logic                w_match;
    logic                w_show_nxt;
    logic                w_timeout;

    assign w_lfsr_step = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    assign w_last_idx  = IDX_W'(r_level - LEVEL_ONE);
    assign w_idx_last  = (r_idx == w_last_idx);
    assign w_cnt_done  = (r_cnt == CNT_LAST);
    assign w_entry     = r_mem[r_idx];
    assign w_match     = (bus.guess == w_entry);
    // The display is registered, so it trails the SHOW state by one cycle; a start drops it at once.
    assign w_show_nxt  = (r_state == S_SHOW) && !bus.start;

`ifdef SIMON_INPUT_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] r_to_cnt;

    // Counts idle INPUT cycles; any guess, start or leaving INPUT restarts it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_to_cnt <= '0;
        end else if (r_state == S_INPUT && !bus.guess_valid && !bus.start) begin
            r_to_cnt <= r_to_cnt + TO_ONE;
        end else begin
            r_to_cnt <= '0;
        end
    end

    assign w_timeout = (r_state == S_INPUT) && (r_to_cnt == TO_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_nxt = r_state;
        w_level_nxt = r_level;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_lfsr_nxt  = r_lfsr;
        w_mem_we    = 1'b0;

        if (bus.start) begin
            w_state_nxt = S_GEN;
            w_level_nxt = LEVEL_ONE;
            w_idx_nxt   = '0;
            w_cnt_nxt   = '0;
            w_lfsr_nxt  = (bus.seed == 16'h0000) ? LFSR_INIT : bus.seed;
        end else begin
            unique case (r_state)
                S_GEN: begin
                    w_mem_we    = 1'b1;
                    w_lfsr_nxt  = w_lfsr_step;
                    w_idx_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_SHOW;
                end
                S_SHOW: begin
                    if (w_cnt_done) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_GAP;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
                S_GAP: begin
                    if (!w_cnt_done) begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end else if (w_idx_last) begin
                        w_cnt_nxt   = '0;
                        w_idx_nxt   = '0;
                        w_state_nxt = S_INPUT;
                    end else begin
                        w_cnt_nxt   = '0;
                        w_idx_nxt   = r_idx + IDX_ONE;
                        w_state_nxt = S_SHOW;
                    end
                end
                S_INPUT: begin
                    if (bus.guess_valid) begin
                        if (!w_match) begin
                            w_state_nxt = S_LOSE;
                        end else if (!w_idx_last) begin
                            w_idx_nxt = r_idx + IDX_ONE;
                        end else if (r_level == LEVEL_MAX) begin
                            w_state_nxt = S_WIN;
                        end else begin
                            w_level_nxt = r_level + LEVEL_ONE;
                            w_state_nxt = S_GEN;
                        end
                    end else if (w_timeout) begin
                        w_state_nxt = S_LOSE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_level      <= '0;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_lfsr       <= LFSR_INIT;
            r_show_en    <= 1'b0;
            r_show_color <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_level      <= w_level_nxt;
            r_idx        <= w_idx_nxt;
            r_cnt        <= w_cnt_nxt;
            r_lfsr       <= w_lfsr_nxt;
            r_show_en    <= w_show_nxt;
            r_show_color <= w_show_nxt ? w_entry : '0;
        end
    end

    // NOTE: the sequence memory has no reset; every entry is written in GEN before it is ever read.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_last_idx] <= r_lfsr[COLOR_W-1:0];
        end
    end

    assign bus.show_en    = r_show_en;
    assign bus.show_color = r_show_color;
    assign bus.busy       = !(r_state inside {S_IDLE, S_WIN, S_LOSE});
    assign bus.win        = (r_state == S_WIN);
    assign bus.lose       = (r_state == S_LOSE);
    assign bus.level      = r_level;
endmodule

// File: tb/tb_simon_seq_engine.sv
// Bench for simon_seq_engine: two instances (MAX_LEN 4 and 2) against a schedule-based game model.
// Build with SIMON_INPUT_TIMEOUT_EN to exercise the input-timeout variant.
module tb_simon_seq_engine;
    localparam int COLOR_W = 2;
    localparam int SHOW    = 2;
    localparam int TO_CYC  = 16;

    typedef enum int {M_IDLE, M_PLAY, M_INPUT, M_WIN, M_LOSE} mphase_t;

    logic clk;
    logic resetn;

    simon_seq_engine_if #(.COLOR_W(COLOR_W), .MAX_LEN(4)) bus0 ();
    simon_seq_engine_if #(.COLOR_W(COLOR_W), .MAX_LEN(2)) bus1 ();

    simon_seq_engine #(
        .COLOR_W(COLOR_W), .MAX_LEN(4), .SHOW_CYCLES(SHOW), .TIMEOUT_CYCLES(TO_CYC)
    ) dut0 (
        .clk(clk), .resetn(resetn), .bus(bus0)
    );

    simon_seq_engine #(
        .COLOR_W(COLOR_W), .MAX_LEN(2), .SHOW_CYCLES(SHOW), .TIMEOUT_CYCLES(TO_CYC)
    ) dut1 (
        .clk(clk), .resetn(resetn), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- game model ----------------
    mphase_t     m_phase [2];
    int          m_level [2];
    int          m_t0    [2];
    int          m_idx   [2];
    int          m_idle  [2];
    logic [15:0] m_lfsr  [2];
    int          m_seq   [2][16];
    int          cyc;

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    endfunction

    function automatic int max_len(input int i);
        return (i == 0) ? 4 : 2;
    endfunction

    task automatic model_step(input int i, input logic st, input logic [15:0] sd,
                              input logic gv, input int g);
        if (st) begin
            m_lfsr[i]   = (sd == 16'h0) ? 16'hACE1 : sd;
            m_seq[i][0] = int'(m_lfsr[i][1:0]);
            m_lfsr[i]   = lfsr_next(m_lfsr[i]);
            m_level[i]  = 1;
            m_phase[i]  = M_PLAY;
            m_t0[i]     = cyc;
        end else if (m_phase[i] == M_PLAY) begin
            // One generate cycle, then SHOW+gap per element.
            if (cyc == m_t0[i] + 1 + m_level[i] * 2 * SHOW) begin
                m_phase[i] = M_INPUT;
                m_idx[i]   = 0;
                m_idle[i]  = 0;
            end
        end else if (m_phase[i] == M_INPUT) begin
            if (gv) begin
                m_idle[i] = 0;
                if (g != m_seq[i][m_idx[i]]) begin
                    m_phase[i] = M_LOSE;
                end else if (m_idx[i] < m_level[i] - 1) begin
                    m_idx[i]++;
                end else if (m_level[i] == max_len(i)) begin
                    m_phase[i] = M_WIN;
                end else begin
                    m_level[i]++;
                    m_seq[i][m_level[i] - 1] = int'(m_lfsr[i][1:0]);
                    m_lfsr[i]  = lfsr_next(m_lfsr[i]);
                    m_phase[i] = M_PLAY;
                    m_t0[i]    = cyc;
                end
            end else begin
                m_idle[i]++;
`ifdef SIMON_INPUT_TIMEOUT_EN
                if (m_idle[i] == TO_CYC) m_phase[i] = M_LOSE;
`endif
            end
        end
    endtask

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 2; i++) begin
                m_phase[i] = M_IDLE;
                m_level[i] = 0;
                m_idx[i]   = 0;
                m_idle[i]  = 0;
                m_t0[i]    = 0;
                m_lfsr[i]  = 16'hACE1;
            end
        end else begin
            cyc++;
            model_step(0, bus0.start, bus0.seed, bus0.guess_valid, int'(bus0.guess));
            model_step(1, bus1.start, bus1.seed, bus1.guess_valid, int'(bus1.guess));
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (resetn) begin
            for (int i = 0; i < 2; i++) begin
                int d;
                int e_en;
                int e_col;
                int a_en, a_col, a_busy, a_win, a_lose, a_lvl;
                e_en  = 0;
                e_col = 0;
                if (m_phase[i] == M_PLAY) begin
                    d = cyc - m_t0[i] - 2;
                    if (d >= 0 && d < m_level[i] * 2 * SHOW && (d % (2 * SHOW)) < SHOW) begin
                        e_en  = 1;
                        e_col = m_seq[i][d / (2 * SHOW)];
                    end
                end
                if (i == 0) begin
                    a_en = int'(bus0.show_en); a_col = int'(bus0.show_color); a_busy = int'(bus0.busy);
                    a_win = int'(bus0.win); a_lose = int'(bus0.lose); a_lvl = int'(bus0.level);
                end else begin
                    a_en = int'(bus1.show_en); a_col = int'(bus1.show_color); a_busy = int'(bus1.busy);
                    a_win = int'(bus1.win); a_lose = int'(bus1.lose); a_lvl = int'(bus1.level);
                end
                check($sformatf("cmp%0d_show_en@%0d", i, cyc), a_en, e_en);
                check($sformatf("cmp%0d_show_color@%0d", i, cyc), a_col, e_col);
                check($sformatf("cmp%0d_busy@%0d", i, cyc), a_busy,
                      int'(m_phase[i] == M_PLAY || m_phase[i] == M_INPUT));
                check($sformatf("cmp%0d_win@%0d", i, cyc), a_win, int'(m_phase[i] == M_WIN));
                check($sformatf("cmp%0d_lose@%0d", i, cyc), a_lose, int'(m_phase[i] == M_LOSE));
                check($sformatf("cmp%0d_level@%0d", i, cyc), a_lvl, m_level[i]);
            end
        end
    end

    // Colours displayed by instance 0, one entry per rising show_en.
    int   cap [$];
    logic prev_en = 1'b0;
    always @(negedge clk) begin
        if (bus0.show_en && !prev_en) cap.push_back(int'(bus0.show_color));
        prev_en = bus0.show_en;
    end

    // ---------------- stimulus helpers (called at a falling edge) ----------------
    task automatic drive(input int i, input logic st, input logic [15:0] sd,
                         input logic gv, input logic [1:0] g);
        if (i == 0) begin
            bus0.start = st; bus0.seed = sd; bus0.guess_valid = gv; bus0.guess = g;
        end else begin
            bus1.start = st; bus1.seed = sd; bus1.guess_valid = gv; bus1.guess = g;
        end
    endtask

    task automatic pulse_start(input int i, input logic [15:0] sd);
        drive(i, 1'b1, sd, 1'b0, 2'd0);
        @(negedge clk);
        drive(i, 1'b0, 16'h0, 1'b0, 2'd0);
    endtask

    task automatic guess(input int i, input logic [1:0] g);
        drive(i, 1'b0, 16'h0, 1'b1, g);
        @(negedge clk);
        drive(i, 1'b0, 16'h0, 1'b0, 2'd0);
    endtask

    task automatic wait_input(input int i);
        int k;
        for (k = 0; k < 300; k++) begin
            if (m_phase[i] == M_INPUT) break;
            @(negedge clk);
        end
        if (k == 300) check($sformatf("wait_input%0d_timeout", i), 0, 1);
    endtask

    task automatic check_seq(input string name, input int n, input int c0, input int c1, input int c2);
        int exp_c [3];
        exp_c = '{c0, c1, c2};
        check({name, "_count"}, cap.size(), n);
        for (int k = 0; k < n && k < 3; k++) begin
            if (k < cap.size()) check($sformatf("%s_%0d", name, k), cap[k], exp_c[k]);
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int k;
        cyc    = 0;
        resetn = 1'b0;
        drive(0, 1'b0, 16'h0, 1'b0, 2'd0);
        drive(1, 1'b0, 16'h0, 1'b0, 2'd0);
        repeat (3) @(negedge clk);
        check("rst_level", int'(bus0.level), 0);
        check("rst_busy", int'(bus0.busy), 0);
        check("rst_show_en", int'(bus0.show_en), 0);
        check("rst_win_lose", int'({bus1.win, bus1.lose}), 0);
        resetn = 1'b1;
        @(negedge clk);

        // Seed 1 produces colours 1, 2, 0 over three levels.
        pulse_start(0, 16'h0001);
        cap.delete();
        wait_input(0);
        check_seq("seq_l1", 1, 1, 0, 0);
        guess(0, 2'd1);
        cap.delete();
        wait_input(0);
        check_seq("seq_l2", 2, 1, 2, 0);
        check("level_l2", int'(bus0.level), 2);
        guess(0, 2'd1);
        guess(0, 2'd2);
        cap.delete();
        wait_input(0);
        check_seq("seq_l3", 3, 1, 2, 0);
        check("level_l3", int'(bus0.level), 3);

        // Start while waiting for input restarts at level 1.
        pulse_start(0, 16'h0001);
        check("restart_level", int'(bus0.level), 1);
        check("restart_busy", int'(bus0.busy), 1);

        // Asynchronous reset in the middle of a displayed element.
        for (k = 0; k < 20; k++) begin
            if (bus0.show_en) break;
            @(negedge clk);
        end
        check("show_seen_before_reset", int'(k < 20), 1);
        #2 resetn = 1'b0;
        #1;
        check("async_rst_show_en", int'(bus0.show_en), 0);
        check("async_rst_level", int'(bus0.level), 0);
        check("async_rst_busy", int'(bus0.busy), 0);
        check("async_rst_win_lose", int'({bus0.win, bus0.lose}), 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Zero seed falls back to 16'hACE1, whose low bits give colour 1.
        pulse_start(0, 16'h0000);
        cap.delete();
        wait_input(0);
        check_seq("seed0_first", 1, 1, 0, 0);

        // Wrong second guess at level 2 loses; later guesses change nothing.
        pulse_start(0, 16'h0001);
        wait_input(0);
        guess(0, 2'd1);
        wait_input(0);
        guess(0, 2'd1);
        guess(0, 2'd3);
        check("lose_flag", int'(bus0.lose), 1);
        check("lose_busy", int'(bus0.busy), 0);
        guess(0, 2'd1);
        guess(0, 2'd2);
        repeat (2) @(negedge clk);
        check("lose_sticky", int'(bus0.lose), 1);
        check("lose_no_win", int'(bus0.win), 0);
        check("lose_level", int'(bus0.level), 2);

        // MAX_LEN=2 instance: clearing level 2 wins.
        pulse_start(1, 16'h0001);
        wait_input(1);
        guess(1, 2'd1);
        wait_input(1);
        guess(1, 2'd1);
        guess(1, 2'd2);
        check("win_flag", int'(bus1.win), 1);
        check("win_busy", int'(bus1.busy), 0);
        check("win_no_lose", int'(bus1.lose), 0);
        check("win_level", int'(bus1.level), 2);
        repeat (3) @(negedge clk);
        check("win_sticky", int'(bus1.win), 1);

        // Idle in INPUT for 100 cycles.
        pulse_start(0, 16'h0001);
        wait_input(0);
        repeat (100) @(negedge clk);
`ifdef SIMON_INPUT_TIMEOUT_EN
        check("timeout_lose", int'(bus0.lose), 1);
        check("timeout_busy", int'(bus0.busy), 0);
`else
        check("no_timeout_busy", int'(bus0.busy), 1);
        check("no_timeout_lose", int'(bus0.lose), 0);
        check("no_timeout_level", int'(bus0.level), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
